// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
`timescale 1ns/1ps
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } rx_state_e;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Frame shape: 8 data bits, no parity, 1 stop bit
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte strobe, byte value and FSM state for debug.
// Handshake: rx_dv is a one-cycle valid strobe with no ready; rx_byte is
// meaningful from the strobe cycle onward and holds until the next strobe.
`timescale 1ns/1ps
interface uart_rx_if;
  import uart_pkg::*;

  logic       rx_dv;
  logic [7:0] rx_byte;
  rx_state_e  state;

  modport master (output rx_dv, output rx_byte, output state);
  modport slave  (input  rx_dv, input  rx_byte, input  state);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two stages; reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Receiver FSM: finds the start-bit midpoint, samples 8 data bits LSB first
// one bit period apart, then strobes the assembled byte at the stop midpoint.
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_s,
  uart_rx_if.master   rx_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_e        state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q,   rx_dv_d;

  // Next-state and datapath decisions; rx_dv defaults low so it pulses once
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    rx_dv_d   = 1'b0;

    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = RX_START;
      end

      RX_START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          // A line that is high again at the midpoint was only a glitch
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        // Stop-bit level is deliberately ignored: framing errors still deliver
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          rx_byte_d = shift_q;
          rx_dv_d   = 1'b1;
          state_d   = RX_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      RX_CLEANUP: begin
        state_d = RX_IDLE;
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Register all FSM state and outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      rx_dv_q   <= rx_dv_d;
    end
  end

  assign rx_out.rx_dv   = rx_dv_q;
  assign rx_out.rx_byte = rx_byte_q;
  assign rx_out.state   = state_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver top: synchronizes the serial line and runs the receive FSM.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_nRst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  logic rx_s;

  uart_rx_if rx_bus ();

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_nRst),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk    (i_Clock),
    .rst_n  (i_nRst),
    .rx_s   (rx_s),
    .rx_out (rx_bus.master)
  );

  assign o_Rx_DV   = rx_bus.rx_dv;
  assign o_Rx_Byte = rx_bus.rx_byte;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: drives 8N1 frames bit by bit and
// checks strobe count, width, byte value and strobe timing against a model.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = DEFAULT_CLKS_PER_BIT;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;
  localparam int TOL  = 3;
  localparam int TCLK = 10;

  // ---------------- clock / reset ----------------
  logic i_Clock     = 1'b0;
  logic i_nRst      = 1'b0;
  logic i_Rx_Serial = 1'b1;

  always #5 i_Clock = ~i_Clock;

  uart_rx_if rx_bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (i_Clock),
    .i_nRst      (i_nRst),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_DV     (rx_bus.rx_dv),
    .o_Rx_Byte   (rx_bus.rx_byte)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  longint      start_q[$];
  logic [7:0]  got_q[$];
  longint      got_t_q[$];
  logic [7:0]  last_byte = 8'h00;

  // ---------------- output monitor ----------------
  logic       dv_prev   = 1'b0;
  logic [7:0] byte_prev = 8'h00;

  always @(negedge i_Clock) begin
    if (dv_prev) begin
      checks++;
      assert (rx_bus.rx_dv === 1'b0) else begin
        errors++;
        $error("FAIL dv_width observed=%b expected=0", rx_bus.rx_dv);
      end
    end
    if (i_nRst && (rx_bus.rx_byte !== byte_prev)) begin
      checks++;
      assert (rx_bus.rx_dv === 1'b1) else begin
        errors++;
        $error("FAIL byte_changed_without_strobe observed=0x%0h expected=0x%0h",
               rx_bus.rx_byte, byte_prev);
      end
    end
    if (rx_bus.rx_dv === 1'b1) begin
      got_q.push_back(rx_bus.rx_byte);
      got_t_q.push_back($time);
    end
    dv_prev   = rx_bus.rx_dv;
    byte_prev = rx_bus.rx_byte;
  end

  // ---------------- check helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp);
    checks++;
    assert ((obs >= exp - TOL) && (obs <= exp + TOL)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
    end
  endtask

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic drive_bit(input logic v, input int ncyc);
    i_Rx_Serial = v;
    repeat (ncyc) @(negedge i_Clock);
  endtask

  task automatic drive_frame(input logic [7:0] b);
    exp_q.push_back(b);
    start_q.push_back($time);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i], CPB);
    drive_bit(1'b1, CPB);
  endtask

  // Wait (bounded) for the next strobe and compare against the scoreboard head
  task automatic expect_strobe(input string tag);
    int         n;
    logic [7:0] eb;
    longint     st;
    n = 0;
    while (got_q.size() == 0 && n < 2 * CPB) begin
      @(negedge i_Clock);
      n++;
    end
    eb = exp_q.pop_front();
    st = start_q.pop_front();
    checks++;
    assert (got_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_strobe expected=0x%0h", tag, eb);
    end
    if (got_q.size() > 0) begin
      check({tag, "_byte"}, 64'(got_q.pop_front()), 64'(eb));
      check_near({tag, "_latency"}, (got_t_q.pop_front() - st) / TCLK, LAT);
      last_byte = eb;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rnd_b;
    logic [7:0] abort_b;
    logic [7:0] ghost_b;
    longint     strobe1_t;
    longint     low_end_t;
    longint     sample_t;

    rnd_b   = 8'($urandom_range(0, 255));
    abort_b = 8'($urandom_range(0, 255));

    // Reset / idle
    @(negedge i_Clock);
    check("reset_dv", 64'(rx_bus.rx_dv), 64'(1'b0));
    check("reset_byte", 64'(rx_bus.rx_byte), 64'h00);
    i_nRst = 1'b1;
    drive_bit(1'b1, 1000);
    check("idle_no_strobe", 64'(got_q.size()), 64'd0);
    check("idle_byte", 64'(rx_bus.rx_byte), 64'h00);

    // Nominal frame 0x55
    drive_frame(8'h55);
    expect_strobe("nominal");
    check("nominal_single", 64'(got_q.size()), 64'd0);

    // Framing error: 0x55 with the line held low 2000 clocks after D7
    exp_q.push_back(8'h55);
    start_q.push_back($time);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(rnd_bit(8'h55, i), CPB);
    drive_bit(1'b0, 2000);
    low_end_t = $time;
    i_Rx_Serial = 1'b1;
    check("framing_one_strobe", 64'(got_q.size()), 64'd1);
    strobe1_t = (got_t_q.size() > 0) ? got_t_q[0] : $time;
    expect_strobe("framing");
    // The low line re-arms the receiver right after the strobe; the model
    // samples it one bit period apart from the next start midpoint.
    ghost_b = 8'h00;
    for (int i = 0; i < DATA_BITS; i++) begin
      sample_t   = strobe1_t + longint'(HALF + (i + 1) * CPB) * TCLK;
      ghost_b[i] = (sample_t >= low_end_t);
    end
    while ($time < strobe1_t + longint'(9 * CPB) * TCLK) @(negedge i_Clock);
    check("framing_no_early_strobe", 64'(got_q.size()), 64'd0);
    exp_q.push_back(ghost_b);
    start_q.push_back(strobe1_t);
    expect_strobe("framing_next");

    // Glitch rejection: 2000 ns low pulse on an idle line
    drive_bit(1'b0, 200);
    drive_bit(1'b1, 2 * CPB);
    check("glitch_no_strobe", 64'(got_q.size()), 64'd0);
    check("glitch_byte_held", 64'(rx_bus.rx_byte), 64'(last_byte));

    // Back-to-back frames with a one-bit stop, plus one random byte
    drive_frame(8'hA5);
    drive_frame(8'h3C);
    drive_frame(rnd_b);
    check("b2b_strobe_count", 64'(got_q.size()), 64'd3);
    if (got_t_q.size() >= 2)
      check_near("b2b_spacing", (got_t_q[1] - got_t_q[0]) / TCLK, 10 * CPB);
    expect_strobe("b2b_a5");
    expect_strobe("b2b_3c");
    expect_strobe("b2b_rand");

    // Mid-frame reset during D3
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(abort_b[i], CPB);
    drive_bit(abort_b[3], CPB / 2);
    i_nRst = 1'b0;
    drive_bit(abort_b[3], 3);
    check("midreset_dv", 64'(rx_bus.rx_dv), 64'(1'b0));
    check("midreset_byte", 64'(rx_bus.rx_byte), 64'h00);
    i_nRst = 1'b1;
    drive_bit(1'b1, 2 * CPB);
    check("midreset_no_strobe", 64'(got_q.size()), 64'd0);
    check("midreset_byte_after", 64'(rx_bus.rx_byte), 64'h00);
    drive_frame(8'h81);
    expect_strobe("after_reset_81");

    drive_bit(1'b1, 100);
    check("final_no_extra_strobe", 64'(got_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rnd_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
